// File: rtl/sru_iter.sv
// Iterative shift-right unit: LSR/ROR/RRC/ASR, one bit position per clock, start/busy/done handshake.
// Optional left shifts (dir port) enabled by defining SRU_LEFT_EN.
module sru_iter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       sel,
  input  logic             cin,
`ifdef SRU_LEFT_EN
  input  logic             dir,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cout
);

  localparam logic [1:0] SEL_LSR = 2'b00;
  localparam logic [1:0] SEL_ROR = 2'b01;
  localparam logic [1:0] SEL_RRC = 2'b10;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_f, w_f_nxt;
  logic             r_cout, w_cout_nxt;
  logic [AMT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_sel, w_sel_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_fill;
`ifdef SRU_LEFT_EN
  logic             r_dir, w_dir_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_f     <= '0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
      r_sel   <= SEL_LSR;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SRU_LEFT_EN
      r_dir   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_f     <= w_f_nxt;
      r_cout  <= w_cout_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef SRU_LEFT_EN
      r_dir   <= w_dir_nxt;
`endif
    end
  end

  // Next-state, one-bit step datapath and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_f_nxt     = r_f;
    w_cout_nxt  = r_cout;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_fill      = 1'b0;
`ifdef SRU_LEFT_EN
    w_dir_nxt   = r_dir;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_f_nxt     = x;
          w_cout_nxt  = cin;
          w_cnt_nxt   = amt;
          w_sel_nxt   = sel;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_SHIFT;
`ifdef SRU_LEFT_EN
          w_dir_nxt   = dir;
`endif
        end
      end
      ST_SHIFT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - AMT_W'(1);
`ifdef SRU_LEFT_EN
          if (r_dir) begin
            // Arithmetic left fills zero, same as logical
            case (r_sel)
              SEL_ROR: w_fill = r_f[WIDTH-1];
              SEL_RRC: w_fill = r_cout;
              default: w_fill = 1'b0;
            endcase
            w_f_nxt    = {r_f[WIDTH-2:0], w_fill};
            w_cout_nxt = r_f[WIDTH-1];
          end else
`endif
          begin
            case (r_sel)
              SEL_LSR: w_fill = 1'b0;
              SEL_ROR: w_fill = r_f[0];
              SEL_RRC: w_fill = r_cout;
              default: w_fill = r_f[WIDTH-1];
            endcase
            w_f_nxt    = {w_fill, r_f[WIDTH-1:1]};
            w_cout_nxt = r_f[0];
          end
        end else begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy = r_busy;
  assign done = r_done;
  assign f    = r_f;
  assign cout = r_cout;

endmodule

// File: tb/tb_sru_iter.sv
// Self-checking bench for sru_iter (WIDTH=8): directed table, corner sequences, randomized ops vs. model.
module tb_sru_iter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] x;
  logic [2:0] amt;
  logic [1:0] sel;
  logic       cin;
`ifdef SRU_LEFT_EN
  logic       dir;
`endif
  logic       busy;
  logic       done;
  logic [7:0] f;
  logic       cout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sru_iter #(.WIDTH(8), .AMT_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .amt   (amt),
    .sel   (sel),
    .cin   (cin),
`ifdef SRU_LEFT_EN
    .dir   (dir),
`endif
    .busy  (busy),
    .done  (done),
    .f     (f),
    .cout  (cout)
  );

  typedef struct {
    logic [7:0] x;
    logic [2:0] amt;
    logic [1:0] sel;
    logic       cin;
    logic       dir;
    logic [7:0] ef;
    logic       ec;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Whole-operation result straight from the mode definitions (shifts/rotations of the operand)
  function automatic void model(input logic [7:0] ix, input int k, input logic [1:0] s,
                                input logic c, input logic d,
                                output logic [7:0] of, output logic oc);
    logic [15:0] dbl;
    logic [8:0]  v9;
    logic [17:0] r18;
    int          k9;
    of = ix;
    oc = c;
    if (k == 0) return;
    k9 = k % 9;
    v9 = {c, ix};
    if (!d) begin
      case (s)
        2'd0: begin of = ix >> k; oc = ix[k-1]; end
        2'd1: begin dbl = {ix, ix} >> k; of = dbl[7:0]; oc = of[7]; end
        2'd2: begin r18 = {v9, v9} >> k9; of = r18[7:0]; oc = r18[8]; end
        default: begin of = 8'($signed(ix) >>> k); oc = ix[k-1]; end
      endcase
    end else begin
      case (s)
        2'd1: begin dbl = {ix, ix} << k; of = dbl[15:8]; oc = of[0]; end
        2'd2: begin r18 = {v9, v9} << k9; of = r18[16:9]; oc = r18[17]; end
        default: begin of = ix << k; oc = ix[8-k]; end
      endcase
    end
  endfunction

  // Issue one op at a negedge, wait for done (bounded), check latency, busy span and result
  task automatic do_op(input logic [7:0] ix, input logic [2:0] iamt, input logic [1:0] isel,
                       input logic icin, input logic idir, input bit noise,
                       input logic [7:0] ef, input logic ec, input string nm);
    int cyc;
    int bc;
    x = ix; amt = iamt; sel = isel; cin = icin; start = 1'b1;
`ifdef SRU_LEFT_EN
    dir = idir;
`endif
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    bc  = 0;
    while (!done && cyc < 40) begin
      if (busy) bc++;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        x = 8'($urandom); amt = 3'($urandom); sel = 2'($urandom); cin = 1'($urandom);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
    end
    chk({nm, ".lat"},  cyc, int'(iamt) + 1);
    chk({nm, ".busy"}, bc,  int'(iamt) + 1);
    chk({nm, ".bz_at_done"}, int'(busy), 0);
    chk({nm, ".f"},    int'(f),    int'(ef));
    chk({nm, ".cout"}, int'(cout), int'(ec));
    if (idir === 1'bx) $display("unreachable");
  endtask

  initial begin
    logic [7:0] ef;
    logic       ec;
    logic [7:0] rx;
    logic [2:0] ra;
    logic [1:0] rs;
    logic       rc;
    logic       rd;

    rst = 1'b1; start = 1'b0; x = '0; amt = '0; sel = '0; cin = 1'b0;
`ifdef SRU_LEFT_EN
    dir = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.f", int'(f), 0);
    chk("rst.cout", int'(cout), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    // x = 10100111 directed vectors, expectations derived by hand
    tbl.push_back('{8'hA7, 3'd3, 2'd0, 1'b0, 1'b0, 8'b00010100, 1'b1});
    tbl.push_back('{8'hA7, 3'd1, 2'd1, 1'b0, 1'b0, 8'b11010011, 1'b1});
    tbl.push_back('{8'hA7, 3'd1, 2'd2, 1'b0, 1'b0, 8'b01010011, 1'b1});
    tbl.push_back('{8'hA7, 3'd2, 2'd2, 1'b0, 1'b0, 8'b10101001, 1'b1});
    tbl.push_back('{8'hA7, 3'd4, 2'd3, 1'b1, 1'b0, 8'b11111010, 1'b0});
    tbl.push_back('{8'hA7, 3'd0, 2'd0, 1'b1, 1'b0, 8'hA7,       1'b1});
    tbl.push_back('{8'hA7, 3'd0, 2'd2, 1'b0, 1'b0, 8'hA7,       1'b0});
    tbl.push_back('{8'hA7, 3'd7, 2'd0, 1'b1, 1'b0, 8'b00000001, 1'b0});
    tbl.push_back('{8'hA7, 3'd7, 2'd1, 1'b0, 1'b0, 8'b01001111, 1'b0});
    tbl.push_back('{8'hA7, 3'd7, 2'd2, 1'b1, 1'b0, 8'b10011111, 1'b0});
    tbl.push_back('{8'hA7, 3'd7, 2'd3, 1'b0, 1'b0, 8'b11111111, 1'b0});
`ifdef SRU_LEFT_EN
    tbl.push_back('{8'hA7, 3'd2, 2'd0, 1'b0, 1'b1, 8'b10011100, 1'b0});
    tbl.push_back('{8'hA7, 3'd1, 2'd1, 1'b0, 1'b1, 8'b01001111, 1'b1});
    tbl.push_back('{8'hA7, 3'd1, 2'd2, 1'b0, 1'b1, 8'b01001110, 1'b1});
    tbl.push_back('{8'hA7, 3'd2, 2'd3, 1'b1, 1'b1, 8'b10011100, 1'b0});
`endif
    foreach (tbl[i]) begin
      do_op(tbl[i].x, tbl[i].amt, tbl[i].sel, tbl[i].cin, tbl[i].dir, 1'b0,
            tbl[i].ef, tbl[i].ec, $sformatf("tbl%0d", i));
      @(negedge clk);
      chk($sformatf("tbl%0d.done_pulse", i), int'(done), 0);
      chk($sformatf("tbl%0d.hold_f", i), int'(f), int'(tbl[i].ef));
    end

    // start pulses while busy must not disturb the running op
    do_op(8'hA7, 3'd5, 2'd1, 1'b0, 1'b0, 1'b1, 8'b00111101, 1'b0, "noise_ror5");

    // back-to-back: start accepted in the cycle done is high
    do_op(8'h5C, 3'd2, 2'd3, 1'b1, 1'b0, 1'b0, 8'b00010111, 1'b0, "b2b_a");
    do_op(8'h81, 3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 8'b11000000, 1'b1, "b2b_b");
    @(negedge clk);

    // reset mid-SHIFT abandons the op with no done pulse
    x = 8'hFF; amt = 3'd7; sel = 2'd1; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.f", int'(f), 0);
    chk("midrst.cout", int'(cout), 0);
    chk("midrst.busy", int'(busy), 0);
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("midrst.no_done", seen, 0);
    end

    // randomized ops against the model, some with busy-time noise
    for (int i = 0; i < 40; i++) begin
      rx = 8'($urandom); ra = 3'($urandom); rs = 2'($urandom); rc = 1'($urandom);
`ifdef SRU_LEFT_EN
      rd = 1'($urandom);
`else
      rd = 1'b0;
`endif
      model(rx, int'(ra), rs, rc, rd, ef, ec);
      do_op(rx, ra, rs, rc, rd, bit'(i % 3 == 0), ef, ec, $sformatf("rnd%0d", i));
      if (i % 2 == 0) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
